updn_cnt_ctrl: RTL

//  Command sequencer and round-robin arbiter in front of one shared up/down counter.
//  - NREQ requesters each issue a command: LOAD value, count UP n steps, count DOWN n steps, or NOP.
//  - Block grants one requester at a time.
//  - It drives the counter's ld_cnt/updn_cnt/count_enb/data_in.
//  - It watches data_out to stop a count before it wraps.

---
 rtl/updn_cnt_ctrl_pkg.sv | 20 ++
 rtl/updn_cnt_ctrl_rr_arbiter.sv | 43 ++++
 rtl/updn_cnt_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/updn_cnt_ctrl_pkg.sv
// Shared types for the up/down counter command sequencer: command codes,
// sequencer states and the command field width.
package updn_cnt_ctrl_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        NOP  = 2'b00,
        LOAD = 2'b01,
        UP   = 2'b10,
        DOWN = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : updn_cnt_ctrl_pkg

// File: rtl/updn_cnt_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester and
// wraps; the pointer moves only when the winner is actually taken.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NREQ-1:0]  req_i,
    input  logic             advance_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr_q) + off) % NREQ);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
        gnt_o = valid_o ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else if (advance_i && valid_o) begin
            ptr_q <= idx_o;
        end
    end

endmodule : rr_arbiter

// File: rtl/updn_cnt_ctrl.sv
// Command sequencer in front of a shared up/down counter: arbitrates requesters,
// replays the winner's LOAD/UP/DOWN/NOP and stops counts before they wrap.
module updn_cnt_ctrl
    import updn_cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     cmd,
    input  logic [WIDTH*NREQ-1:0] opnd,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  wrap_err,
    output logic                  busy,
    output logic                  ld_cnt,
    output logic                  updn_cnt,
    output logic                  count_enb,
    output logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH-1:0]      data_out
);

    localparam int IDX_W = $clog2(NREQ);

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [NREQ-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             wrap_q, wrap_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             advance;
    logic             at_bound;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_      (rst_),
        .req_i     (req),
        .advance_i (advance),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    assign at_bound = ((cmd_q == UP)   && (data_out == {WIDTH{1'b1}})) ||
                      ((cmd_q == DOWN) && (data_out == '0));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        owner_d   = owner_q;
        gnt_d     = '0;
        wrap_d    = wrap_q;
        advance   = 1'b0;
        ld_cnt    = 1'b0;
        count_enb = 1'b0;
        updn_cnt  = 1'b0;
        data_in   = '0;

        unique case (state_q)
            EXEC: begin
                unique case (cmd_q)
                    LOAD: begin
                        ld_cnt  = 1'b1;
                        data_in = opnd_q;
                        state_d = DONE;
                    end
                    UP, DOWN: begin
                        updn_cnt = (cmd_q == UP);
                        // A finished count takes precedence over a boundary hit.
                        if (rem_q == '0) begin
                            state_d = DONE;
                        end else if (at_bound) begin
                            wrap_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            count_enb = 1'b1;
                            rem_d     = rem_q - 1'b1;
                        end
                    end
                    default: state_d = DONE;
                endcase
            end
            default: begin
                if (state_q == DONE) state_d = IDLE;
                // DONE also arbitrates so the next grant lands on the edge that ends it.
                if (arb_valid) begin
                    advance = 1'b1;
                    state_d = EXEC;
                    cmd_d   = cmd_e'(cmd[arb_idx*CMD_W +: CMD_W]);
                    opnd_d  = opnd[arb_idx*WIDTH +: WIDTH];
                    rem_d   = opnd[arb_idx*WIDTH +: WIDTH];
                    owner_d = arb_gnt;
                    gnt_d   = arb_gnt;
                    wrap_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            cmd_q   <= NOP;
            opnd_q  <= '0;
            rem_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE) ? owner_q : '0;
    assign wrap_err = (state_q == DONE) && wrap_q;

endmodule : updn_cnt_ctrl
